// File: rtl/rapids_fetch_if.sv
// Fetch-stage bus bundle: single-word read channel to the mmu and the
// valid/ready instruction channel toward decode.
interface rapids_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );
endinterface

// File: rtl/rapids_fetch.sv
// Instruction fetch stage: owns the PC, issues one read at a time to the mmu
// and buffers returned words in a 2-entry queue in front of decode.
//
//   state  | meaning
//   IDLE   | out of reset, no fetches issued until go
//   RUN    | fetching; a new read issues whenever a queue slot is free
//   HALTED | no new reads; in-flight read completes, queue keeps draining
module rapids_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              running,
  output logic [ADDR_W-1:0] pc,
  rapids_fetch_if.master    bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state, state_nxt;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              drop;
  logic [DATA_W-1:0] q_data [2];
  logic [ADDR_W-1:0] q_pc   [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              valid, ack, push, pop, issue;

  // req_q doubles as the outstanding flag; acks with no request are ignored
  assign ack   = req_q && bus.mem_ack;
  assign push  = ack && !drop && !redirect;
  assign valid = (count != 2'd0);
  assign pop   = valid && bus.inst_ready && !redirect;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = halt ? HALTED : RUN;
      RUN:     if (halt) state_nxt = HALTED;
      HALTED:  if (go && !halt) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // The in-flight read already owns a queue slot, so it counts against space
  always_comb begin
    running = (state == RUN);
    issue   = (state == RUN) && !redirect && (!req_q || ack) &&
              ((count + {1'b0, req_q}) < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      pc_q   <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      if (issue) begin
        req_q  <= 1'b1;
        addr_q <= pc_q;
      end else if (ack) begin
        req_q  <= 1'b0;
      end

      if (redirect)   pc_q <= redirect_pc;
      else if (issue) pc_q <= pc_q + ADDR_W'(1);

      if (ack)                   drop <= 1'b0;
      else if (redirect && req_q) drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.mem_rdata;
      q_pc[wr_ptr]   <= addr_q;
    end
  end

  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? q_data[rd_ptr] : '0;
  assign bus.inst_pc    = valid ? q_pc[rd_ptr] : '0;
  assign pc             = pc_q;

endmodule
